// File: rtl/a2d_sched_if.sv
// rtl/a2d_sched_if.sv - A2D converter and auxiliary-request bus shared by a2d_sched and its peers
interface a2d_sched_if;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;
    logic        aux_req;
    logic [2:0]  aux_chnnl;
    logic        aux_done;
    logic [11:0] aux_res;

    modport master (
        output strt_cnv, chnnl, aux_done, aux_res,
        input  cnv_cmplt, A2D_res, aux_req, aux_chnnl
    );

    modport slave (
        input  strt_cnv, chnnl, aux_done, aux_res,
        output cnv_cmplt, A2D_res, aux_req, aux_chnnl
    );
endinterface

// File: rtl/a2d_sched.sv
// rtl/a2d_sched.sv - IR line-sensor A2D scan scheduler; define A2D_SCHED_AUX_EN to arbitrate auxiliary conversions
module a2d_sched #(
    parameter int unsigned SETTLE = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_go,
    a2d_sched_if.master        bus,
    output logic               IR_in_en,
    output logic               IR_mid_en,
    output logic               IR_out_en,
    output logic signed [15:0] err,
    output logic               err_vld,
    output logic               busy
);

`ifdef A2D_SCHED_AUX_EN
    localparam bit aux_en = 1'b1;
`else
    localparam bit aux_en = 1'b0;
`endif
    localparam logic [15:0] settle_last = 16'(SETTLE - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SETTLE, ST_CNV_L, ST_WAIT_L, ST_CNV_R, ST_WAIT_R,
        ST_AUX_CNV, ST_AUX_WAIT, ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         pair_q, pair_d;
    logic [15:0]        settle_cnt_q, settle_cnt_d;
    logic [2:0]         emit_q, emit_d;
    logic               strt_cnv_q, strt_cnv_d;
    logic [2:0]         chnnl_q, chnnl_d;
    logic [11:0]        res_l_q, res_l_d;
    logic signed [15:0] acc_q, acc_d;
    logic signed [15:0] err_q, err_d;
    logic               err_vld_q, err_vld_d;
    logic               aux_done_q, aux_done_d;
    logic [11:0]        aux_res_q, aux_res_d;
    logic               busy_q, busy_d;
    logic               scan_pend_q, scan_pend_d;
    logic               in_scan_q, in_scan_d;
    logic               cmplt_prev_q, cmplt_prev_d;

    logic               aux_grant;
    logic               cmplt_rise;
    logic signed [12:0] diff;
    logic signed [15:0] term;

    function automatic logic [2:0] left_ch(input logic [1:0] p);
        case (p)
            2'd0:    return 3'd0;
            2'd1:    return 3'd2;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [2:0] right_ch(input logic [1:0] p);
        case (p)
            2'd0:    return 3'd1;
            2'd1:    return 3'd4;
            default: return 3'd3;
        endcase
    endfunction

    // aux_done_q still high means the requester has not yet seen its result; do not re-grant.
    assign aux_grant  = aux_en & bus.aux_req & ~aux_done_q;
    // Only a fresh rising cnv_cmplt counts, so a level left over from an earlier conversion is never captured.
    assign cmplt_rise = bus.cnv_cmplt & ~cmplt_prev_q;
    assign diff       = {1'b0, bus.A2D_res} - {1'b0, res_l_q};
    assign term       = 16'(diff) <<< pair_q;

    always_comb begin
        state_d      = state_q;
        pair_d       = pair_q;
        settle_cnt_d = settle_cnt_q;
        emit_d       = emit_q;
        strt_cnv_d   = 1'b0;
        chnnl_d      = chnnl_q;
        res_l_d      = res_l_q;
        acc_d        = acc_q;
        err_d        = err_q;
        err_vld_d    = 1'b0;
        aux_done_d   = 1'b0;
        aux_res_d    = aux_res_q;
        in_scan_d    = in_scan_q;
        cmplt_prev_d = bus.cnv_cmplt;
        scan_pend_d  = scan_pend_q | (scan_go & ~in_scan_q);

        case (state_q)
            ST_IDLE: begin
                if (aux_grant) begin
                    state_d    = ST_AUX_CNV;
                    strt_cnv_d = 1'b1;
                    chnnl_d    = bus.aux_chnnl;
                end else if (scan_pend_q) begin
                    state_d     = ST_SETTLE;
                    pair_d      = 2'd0;
                    emit_d      = 3'b001;
                    scan_pend_d = 1'b0;
                    in_scan_d   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == settle_last) begin
                    settle_cnt_d = 16'd0;
                    state_d      = ST_CNV_L;
                    strt_cnv_d   = 1'b1;
                    chnnl_d      = left_ch(pair_q);
                end else begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end
            ST_CNV_L: state_d = ST_WAIT_L;
            ST_WAIT_L: begin
                if (cmplt_rise) begin
                    res_l_d    = bus.A2D_res;
                    state_d    = ST_CNV_R;
                    strt_cnv_d = 1'b1;
                    chnnl_d    = right_ch(pair_q);
                end
            end
            ST_CNV_R: state_d = ST_WAIT_R;
            ST_WAIT_R: begin
                if (cmplt_rise) begin
                    acc_d  = acc_q + term;
                    emit_d = 3'b000;
                    if (pair_q == 2'd2) begin
                        state_d = ST_DONE;
                    end else begin
                        pair_d = pair_q + 2'd1;
                        if (aux_grant) begin
                            state_d    = ST_AUX_CNV;
                            strt_cnv_d = 1'b1;
                            chnnl_d    = bus.aux_chnnl;
                        end else begin
                            state_d = ST_SETTLE;
                            emit_d  = 3'b001 << (pair_q + 2'd1);
                        end
                    end
                end
            end
            ST_AUX_CNV: state_d = ST_AUX_WAIT;
            ST_AUX_WAIT: begin
                if (cmplt_rise) begin
                    aux_res_d  = bus.A2D_res;
                    aux_done_d = 1'b1;
                    if (in_scan_q) begin
                        state_d = ST_SETTLE;
                        emit_d  = 3'b001 << pair_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                err_d     = acc_q;
                err_vld_d = 1'b1;
                acc_d     = 16'sd0;
                in_scan_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pair_q       <= 2'd0;
            settle_cnt_q <= 16'd0;
            emit_q       <= 3'b000;
            strt_cnv_q   <= 1'b0;
            chnnl_q      <= 3'd0;
            res_l_q      <= 12'd0;
            acc_q        <= 16'sd0;
            err_q        <= 16'sd0;
            err_vld_q    <= 1'b0;
            aux_done_q   <= 1'b0;
            aux_res_q    <= 12'd0;
            busy_q       <= 1'b0;
            scan_pend_q  <= 1'b0;
            in_scan_q    <= 1'b0;
            cmplt_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pair_q       <= pair_d;
            settle_cnt_q <= settle_cnt_d;
            emit_q       <= emit_d;
            strt_cnv_q   <= strt_cnv_d;
            chnnl_q      <= chnnl_d;
            res_l_q      <= res_l_d;
            acc_q        <= acc_d;
            err_q        <= err_d;
            err_vld_q    <= err_vld_d;
            aux_done_q   <= aux_done_d;
            aux_res_q    <= aux_res_d;
            busy_q       <= busy_d;
            scan_pend_q  <= scan_pend_d;
            in_scan_q    <= in_scan_d;
            cmplt_prev_q <= cmplt_prev_d;
        end
    end

    assign IR_in_en     = emit_q[0];
    assign IR_mid_en    = emit_q[1];
    assign IR_out_en    = emit_q[2];
    assign err          = err_q;
    assign err_vld      = err_vld_q;
    assign busy         = busy_q;
    assign bus.strt_cnv = strt_cnv_q;
    assign bus.chnnl    = chnnl_q;
    assign bus.aux_done = aux_done_q;
    assign bus.aux_res  = aux_res_q;

endmodule

// File: tb/tb_a2d_sched.sv
// tb/tb_a2d_sched.sv - directed scoreboard bench for a2d_sched with a behavioural A2D responder
module tb_a2d_sched;
    localparam int unsigned SETTLE = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               scan_go = 1'b0;
    logic               ir_in, ir_mid, ir_out;
    logic signed [15:0] err;
    logic               err_vld;
    logic               busy;

    int          checks = 0;
    int          errors = 0;
    int          ch_exp[$];
    int          err_exp[$];
    int          aux_exp[$];
    logic [11:0] res_tbl[8];
    bit          stale_mode = 1'b0;

    a2d_sched_if bus ();

    a2d_sched #(.SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .scan_go  (scan_go),
        .bus      (bus),
        .IR_in_en (ir_in),
        .IR_mid_en(ir_mid),
        .IR_out_en(ir_out),
        .err      (err),
        .err_vld  (err_vld),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic run_scan(input int l0, input int r0, input int l1, input int r1,
                            input int l2, input int r2, input bit aux_mid);
        res_tbl[0] = 12'(l0);
        res_tbl[1] = 12'(r0);
        res_tbl[2] = 12'(l1);
        res_tbl[4] = 12'(r1);
        res_tbl[7] = 12'(l2);
        res_tbl[3] = 12'(r2);
        ch_exp.push_back(0);
        ch_exp.push_back(1);
        ch_exp.push_back(2);
        ch_exp.push_back(4);
        if (aux_mid) ch_exp.push_back(6);
        ch_exp.push_back(7);
        ch_exp.push_back(3);
        err_exp.push_back((r0 - l0) + 2 * (r1 - l1) + 4 * (r2 - l2));
        scan_go = 1'b1;
        tick();
        scan_go = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy !== 1'b0 || ch_exp.size() != 0 || err_exp.size() != 0 || aux_exp.size() != 0)
               && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 1000), 1);
    endtask

    task automatic wait_aux(input string tag);
        int n = 0;
        while (bus.aux_done !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.aux_done), 1);
        bus.aux_req = 1'b0;
    endtask

    // Responds to each strt_cnv after a short latency; stale_mode keeps cnv_cmplt high between conversions.
    initial begin : a2d_model
        logic [11:0] v;
        bus.cnv_cmplt = 1'b0;
        bus.A2D_res   = 12'h000;
        tick();
        forever begin
            if (bus.strt_cnv === 1'b1) begin
                v = res_tbl[bus.chnnl];
                tick();
                tick();
                if (stale_mode) begin
                    bus.cnv_cmplt = 1'b0;
                    tick();
                end
                bus.cnv_cmplt = 1'b1;
                bus.A2D_res   = v;
                tick();
                if (stale_mode) bus.A2D_res = 12'hFFF;
                else bus.cnv_cmplt = 1'b0;
            end else begin
                if (stale_mode) begin
                    bus.cnv_cmplt = 1'b1;
                    bus.A2D_res   = 12'hFFF;
                end else begin
                    bus.cnv_cmplt = 1'b0;
                end
                tick();
            end
        end
    end

    initial begin : monitor
        int e;
        forever begin
            tick();
            chk("emit_onehot", 32'(int'(ir_in) + int'(ir_mid) + int'(ir_out) <= 1), 1);
            if (bus.strt_cnv === 1'b1) begin
                e = (ch_exp.size() != 0) ? ch_exp.pop_front() : 8;
                chk("chnnl", 32'(bus.chnnl), e);
                if (bus.chnnl == 3'd5 || bus.chnnl == 3'd6)
                    chk("aux_emit_low", 32'({ir_in, ir_mid, ir_out}), 0);
            end
            if (err_vld === 1'b1) begin
                e = (err_exp.size() != 0) ? err_exp.pop_front() : 32'h7fffffff;
                chk("err", 32'(err), e);
            end
            if (bus.aux_done === 1'b1) begin
                e = (aux_exp.size() != 0) ? aux_exp.pop_front() : -1;
                chk("aux_res", 32'(bus.aux_res), e);
            end
        end
    end

    initial begin : stim
        int n;
        for (int i = 0; i < 8; i++) res_tbl[i] = 12'h000;
        bus.aux_req   = 1'b0;
        bus.aux_chnnl = 3'd0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_vld", 32'(err_vld), 0);
        chk("rst_emit", 32'({ir_in, ir_mid, ir_out}), 0);
        chk("rst_strt_cnv", 32'(bus.strt_cnv), 0);
        chk("rst_chnnl", 32'(bus.chnnl), 0);
        chk("rst_aux_done", 32'(bus.aux_done), 0);
        chk("rst_aux_res", 32'(bus.aux_res), 0);
        rst = 1'b0;
        tick();

        run_scan(100, 300, 200, 200, 500, 0, 1'b0);
        n = 0;
        while (ir_in !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("settle_start", 32'(ir_in), 1);
        n = 0;
        while (bus.strt_cnv !== 1'b1 && n < int'(SETTLE) + 20) begin
            tick();
            n++;
        end
        chk("settle_len", n, SETTLE);
        wait_idle("scan_basic_done");
        chk("err_basic_hold", 32'(err), -1800);
        chk("busy_after_scan", 32'(busy), 0);

        run_scan(4095, 0, 4095, 0, 4095, 0, 1'b0);
        repeat (20) tick();
        scan_go = 1'b1;
        tick();
        scan_go = 1'b0;
        wait_idle("scan_min_done");
        chk("err_min_hold", 32'(err), -28665);
        repeat (30) tick();
        chk("no_rescan", 32'(busy), 0);

        run_scan(0, 4095, 0, 4095, 0, 4095, 1'b0);
        wait_idle("scan_max_done");
        chk("err_max_hold", 32'(err), 28665);

        stale_mode = 1'b1;
        repeat (3) tick();
        run_scan(10, 20, 10, 20, 10, 20, 1'b0);
        wait_idle("scan_stale_done");
        chk("err_stale_hold", 32'(err), 70);
        stale_mode = 1'b0;
        repeat (3) tick();

        run_scan(1, 2, 3, 4, 5, 6, 1'b0);
        n = 0;
        while (ir_out !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("outer_settle_reached", 32'(ir_out), 1);
        #3 rst = 1'b1;
        #1;
        chk("rst_emit_async", 32'(ir_out), 0);
        chk("rst_busy_async", 32'(busy), 0);
        chk("rst_pending_ch", ch_exp.size(), 2);
        ch_exp.delete();
        err_exp.delete();
        tick();
        rst = 1'b0;
        repeat (40) tick();
        chk("rst_err_cleared", 32'(err), 0);
        chk("rst_stays_idle", 32'(busy), 0);

`ifdef A2D_SCHED_AUX_EN
        res_tbl[5] = 12'hABC;
        ch_exp.push_back(5);
        aux_exp.push_back(12'hABC);
        bus.aux_req   = 1'b1;
        bus.aux_chnnl = 3'd5;
        run_scan(100, 300, 200, 200, 500, 0, 1'b0);
        wait_aux("aux_first_done");
        wait_idle("aux_first_scan_done");
        chk("aux_first_err", 32'(err), -1800);

        res_tbl[6] = 12'h123;
        run_scan(7, 9, 40, 30, 300, 310, 1'b1);
        n = 0;
        while (!(bus.strt_cnv === 1'b1 && bus.chnnl == 3'd2) && n < 300) begin
            tick();
            n++;
        end
        chk("mid_left_start", 32'(bus.chnnl), 2);
        tick();
        bus.aux_req   = 1'b1;
        bus.aux_chnnl = 3'd6;
        aux_exp.push_back(12'h123);
        wait_aux("aux_mid_done");
        wait_idle("aux_mid_scan_done");
        chk("aux_mid_err", 32'(err), 22);
        chk("aux_res_hold", 32'(bus.aux_res), 12'h123);
`else
        res_tbl[5]    = 12'hABC;
        bus.aux_req   = 1'b1;
        bus.aux_chnnl = 3'd5;
        run_scan(7, 9, 40, 30, 300, 310, 1'b0);
        wait_idle("noaux_scan_done");
        chk("noaux_err", 32'(err), 22);
        chk("noaux_aux_res", 32'(bus.aux_res), 0);
        chk("noaux_aux_done", 32'(bus.aux_done), 0);
        bus.aux_req = 1'b0;
`endif

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/a2d_sched.md
A2D_SCHED -- requirements
Module: a2d_sched

Interface
REQ-001 SETTLE parameter, default 4096: emitter settle time in clk cycles before the first conversion of each IR pair; legal range 1..65535.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 scan_go  input  1  single-cycle request to start one full IR scan.
REQ-005 aux_req  input  1  level request for one auxiliary conversion; held until aux_done.
REQ-006 aux_chnnl  input  3  channel for the auxiliary conversion; sampled on grant.
REQ-007 aux_done  output  1  one-cycle pulse; aux_res valid on the same cycle.
REQ-008 aux_res  output  12  last auxiliary conversion result.
REQ-009 strt_cnv  output  1  one-cycle start pulse to the A2D interface.
REQ-010 chnnl  output  3  A2D channel; stable from strt_cnv until capture.
REQ-011 cnv_cmplt  input  1  A2D conversion complete.
REQ-012 A2D_res  input  12  A2D result; valid while cnv_cmplt is high.
REQ-013 IR_in_en, IR_mid_en, IR_out_en  output  1 each  IR emitter enables; at most one high at any time.
REQ-014 err  output  16  signed weighted line error; updated only at scan end.
REQ-015 err_vld  output  1  one-cycle pulse when err updates.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 States: IDLE, SETTLE, CNV_L, WAIT_L, CNV_R, WAIT_R, AUX_CNV, AUX_WAIT, DONE.
REQ-018 Pair order: inner (L ch0, R ch1, weight 1), mid (L ch2, R ch4, weight 2), outer (L ch7, R ch3, weight 4).
REQ-019 scan_go sets scan_pend when no scan is in progress; scan_go during a scan is ignored; scan_pend clears on entry to SETTLE of the inner pair.
REQ-020 IDLE: aux_req has priority over scan_pend; aux -> AUX_CNV; else scan_pend -> SETTLE (inner pair); else stay.
REQ-021 SETTLE: the current pair's emitter is high and a 16-bit counter counts SETTLE cycles, then -> CNV_L.
REQ-022 CNV_L/CNV_R: strt_cnv is pulsed for exactly one cycle with chnnl set to the left/right channel -> WAIT_L/WAIT_R.
REQ-023 WAIT_x: A2D_res is captured on the first cycle cnv_cmplt is high; a high cnv_cmplt on the strt_cnv cycle itself is ignored.
REQ-024 After WAIT_R: accumulator += (R - L) << log2(weight), using a 13-bit signed difference; the emitter drops the same cycle.
REQ-025 Between pairs, a pending aux_req is serviced (AUX_CNV/AUX_WAIT) before the next SETTLE; no emitter is high during an aux conversion.
REQ-026 After the outer pair -> DONE: err <= accumulator, err_vld pulses, accumulator clears -> IDLE.
REQ-027 The accumulator never overflows: |err| <= 4095*7 = 28665.
REQ-028 AUX_CNV latches aux_chnnl and pulses strt_cnv; AUX_WAIT captures into aux_res and pulses aux_done -> resume the interrupted scan, or IDLE.
REQ-029 strt_cnv is never pulsed while a conversion is outstanding; at most one requester owns the A2D at a time.
REQ-030 The A2D has no timeout; the FSM waits indefinitely for cnv_cmplt.

Reset
REQ-031 rst high: state = IDLE, all emitters = 0, strt_cnv = 0, chnnl = 0, err = 0, err_vld = 0, aux_done = 0, aux_res = 0, busy = 0, scan_pend = 0, accumulator = 0, settle counter = 0.
REQ-032 Reset mid-scan aborts the scan; emitters drop asynchronously and no err_vld follows.

Configuration
REQ-033 Macro A2D_SCHED_AUX_EN: when defined, auxiliary arbitration behaves as specified above.
REQ-034 Without A2D_SCHED_AUX_EN: ports remain present; aux_req is ignored, aux_done = 0 and aux_res = 0 permanently, and the AUX states are unreachable.

Verification
REQ-035 SETTLE=8, scan_go; A2D model returns L=100/R=300, L=200/R=200, L=500/R=0 -> err = 200 + 0 - 2000 = -1800, one err_vld, channel order 0, 1, 2, 4, 7, 3.
REQ-036 aux_req with aux_chnnl=5 and scan_go in the same idle cycle -> ch5 converts first, aux_done with aux_res=0xABC, then the scan runs to completion.
REQ-037 aux_req raised during mid-pair WAIT_L -> the mid pair completes, ch6 aux conversion runs with all emitters low, then the outer SETTLE follows.
REQ-038 rst asserted during outer SETTLE -> IR_out_en low before the next clk edge, no err_vld, busy = 0.
REQ-039 cnv_cmplt held high across strt_cnv -> the stale value is not captured; the next rising sample is captured.
REQ-040 Build without A2D_SCHED_AUX_EN and hold aux_req high -> no aux strt_cnv, aux_done never pulses, scan unaffected.
